// File: rtl/flag_status_unit_if.sv
// Bundle of the ALU-side stimulus and the flag/stack status signals for flag_status_unit.
// The master drives the writeback and stack controls; the slave (the flag unit) drives status.
interface flag_status_unit_if #(
   parameter int WIDTH = 16
);
   logic             stall;
   logic             flagWe;
   logic [3:0]       flagMask;
   logic             isSub;
   logic [WIDTH-1:0] aluResult;
   logic             opAMsb;
   logic             opBMsb;
   logic             carryOut;
   logic             loadEn;
   logic [3:0]       loadFlags;
   logic             push;
   logic             pop;
   logic             zFlag;
   logic             carryFlag;
   logic             signFlag;
   logic             overflowFlag;
   logic             stackEmpty;
   logic             stackFull;
   logic             stackErr;

   modport master (
      output stall, flagWe, flagMask, isSub, aluResult, opAMsb, opBMsb, carryOut,
             loadEn, loadFlags, push, pop,
      input  zFlag, carryFlag, signFlag, overflowFlag, stackEmpty, stackFull, stackErr
   );

   modport slave (
      input  stall, flagWe, flagMask, isSub, aluResult, opAMsb, opBMsb, carryOut,
             loadEn, loadFlags, push, pop,
      output zFlag, carryFlag, signFlag, overflowFlag, stackEmpty, stackFull, stackErr
   );
endinterface

// File: rtl/flag_status_unit.sv
// Registered Z/C/S/V status flags with per-flag writeback masks, a direct load path
// and a small LIFO stack used to save/restore flags around interrupts.
// Flag vectors are ordered {V,S,C,Z}.
module flag_status_unit #(
   parameter int WIDTH       = 16,
   parameter int STACK_DEPTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   flag_status_unit_if.slave bus
);
   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [3:0]       flagsReg;
   logic [PTR_W-1:0] ptrReg;
   logic             errReg;
   logic [3:0]       stackMem [STACK_DEPTH];

   logic             compZ;
   logic             compS;
   logic             compV;
   logic [3:0]       computed;
   logic [3:0]       wbFlags;
   logic [3:0]       stackTop;
   logic [IDX_W-1:0] topIdx;
   logic             isEmpty;
   logic             isFull;
   logic             popOk;
   logic             popErr;
   logic             pushReq;
   logic             pushOk;
   logic             pushErr;

   // Flag values derived from the current ALU writeback
   assign compZ    = (bus.aluResult == '0);
   assign compS    = bus.aluResult[WIDTH-1];
   assign compV    = bus.isSub ? ((bus.opAMsb != bus.opBMsb) && (compS != bus.opAMsb))
                               : ((bus.opAMsb == bus.opBMsb) && (compS != bus.opAMsb));
   assign computed = {compV, compS, bus.carryOut, compZ};

   // Masked merge: flags whose mask bit is clear keep their registered value
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : gMerge
         assign wbFlags[gi] = bus.flagMask[gi] ? computed[gi] : flagsReg[gi];
      end
   endgenerate

   // Stack occupancy and the qualified push/pop decisions; a push alongside a pop is dropped
   assign isEmpty  = (ptrReg == '0);
   assign isFull   = (ptrReg == PTR_W'(STACK_DEPTH));
   assign popOk    = bus.pop && !isEmpty;
   assign popErr   = bus.pop && isEmpty;
   assign pushReq  = bus.push && !bus.pop;
   assign pushOk   = pushReq && !isFull;
   assign pushErr  = pushReq && isFull;
   assign topIdx   = ptrReg[IDX_W-1:0] - IDX_W'(1);
   assign stackTop = stackMem[topIdx];

   // Live flags, stack pointer and sticky error; pop beats load beats writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flagsReg <= '0;
         ptrReg   <= '0;
         errReg   <= 1'b0;
      end else if (!bus.stall) begin
         if (popOk) begin
            flagsReg <= stackTop;
            ptrReg   <= ptrReg - PTR_W'(1);
         end else begin
            if (bus.loadEn) begin
               flagsReg <= bus.loadFlags;
            end else if (bus.flagWe) begin
               flagsReg <= wbFlags;
            end
            if (pushOk) begin
               ptrReg <= ptrReg + PTR_W'(1);
            end
         end
         if (popErr || pushErr) begin
            errReg <= 1'b1;
         end
      end
   end

   // Stack storage saves the pre-update flags; contents need no reset
   always_ff @(posedge clk) begin
      if (!bus.stall && pushOk) begin
         stackMem[ptrReg[IDX_W-1:0]] <= flagsReg;
      end
   end

   assign bus.zFlag        = flagsReg[0];
   assign bus.carryFlag    = flagsReg[1];
   assign bus.signFlag     = flagsReg[2];
   assign bus.overflowFlag = flagsReg[3];
   assign bus.stackEmpty   = isEmpty;
   assign bus.stackFull    = isFull;
   assign bus.stackErr     = errReg;
endmodule

// File: tb/tb_flag_status_unit.sv
// Directed bench for flag_status_unit: each step pushes its expected status to a
// scoreboard queue, and the entry is popped and compared once the DUT has clocked.
module tb_flag_status_unit;
   logic clk;
   logic rst_n;

   flag_status_unit_if #(.WIDTH(16)) bus ();

   flag_status_unit #(.WIDTH(16), .STACK_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      tag;
      logic [3:0] flags;
      logic       empty;
      logic       full;
      logic       err;
   } exp_t;

   exp_t sbQ[$];
   int   testCount = 0;
   int   failCount = 0;

   task automatic pushExp(input string tag, input logic [3:0] f, input logic e,
                          input logic fu, input logic er);
      exp_t x;
      x.tag = tag; x.flags = f; x.empty = e; x.full = fu; x.err = er;
      sbQ.push_back(x);
   endtask

   task automatic checkOut();
      exp_t       x;
      logic [3:0] obs;
      testCount++;
      if (sbQ.size() == 0) begin
         failCount++;
         $display("FAIL scoreboard: queue empty, observed output with no expected entry");
         return;
      end
      x   = sbQ.pop_front();
      obs = {bus.overflowFlag, bus.signFlag, bus.carryFlag, bus.zFlag};
      assert (obs === x.flags) else begin
         failCount++;
         $error("FAIL %s flags: got %b expected %b", x.tag, obs, x.flags);
      end
      testCount++;
      assert (bus.stackEmpty === x.empty) else begin
         failCount++;
         $error("FAIL %s stackEmpty: got %b expected %b", x.tag, bus.stackEmpty, x.empty);
      end
      testCount++;
      assert (bus.stackFull === x.full) else begin
         failCount++;
         $error("FAIL %s stackFull: got %b expected %b", x.tag, bus.stackFull, x.full);
      end
      testCount++;
      assert (bus.stackErr === x.err) else begin
         failCount++;
         $error("FAIL %s stackErr: got %b expected %b", x.tag, bus.stackErr, x.err);
      end
      $display("[TB] %s: flags=%b empty=%b full=%b err=%b", x.tag, obs,
               bus.stackEmpty, bus.stackFull, bus.stackErr);
   endtask

   task automatic idle();
      bus.stall = 0; bus.flagWe = 0; bus.flagMask = 4'b0000; bus.isSub = 0;
      bus.aluResult = '0; bus.opAMsb = 0; bus.opBMsb = 0; bus.carryOut = 0;
      bus.loadEn = 0; bus.loadFlags = 4'b0000; bus.push = 0; bus.pop = 0;
   endtask

   // Expected value enters the scoreboard with the stimulus, leaves after the edge
   task automatic step(input string tag, input logic [3:0] f, input logic e,
                       input logic fu, input logic er);
      pushExp(tag, f, e, fu, er);
      @(posedge clk);
      #1;
      checkOut();
      idle();
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      bus.flagWe = 1; bus.flagMask = 4'b1111; bus.aluResult = 16'h0000;
      pushExp("reset", 4'b0000, 1, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOut();
      rst_n = 1'b1;
      idle();
      step("idle", 4'b0000, 1, 0, 0);

      // add overflow: 0x?+0x? -> 0x8000 with positive operands
      bus.flagWe = 1; bus.flagMask = 4'b1111; bus.aluResult = 16'h8000;
      step("add_ovf", 4'b1100, 1, 0, 0);

      // compare-equal, only Z and C updated
      bus.flagWe = 1; bus.flagMask = 4'b0011; bus.isSub = 1; bus.aluResult = 16'h0000;
      bus.carryOut = 1; bus.opAMsb = 1; bus.opBMsb = 1;
      step("cmp_mask", 4'b1111, 1, 0, 0);

      // sub overflow: negative minus positive giving positive
      bus.flagWe = 1; bus.flagMask = 4'b1111; bus.isSub = 1; bus.aluResult = 16'h7ffe;
      bus.opAMsb = 1; bus.opBMsb = 0; bus.carryOut = 1;
      step("sub_ovf", 4'b1010, 1, 0, 0);

      // stall holds flags, then release applies the writeback
      bus.loadEn = 1; bus.loadFlags = 4'b0000;
      step("load0", 4'b0000, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         bus.stall = 1; bus.flagWe = 1; bus.flagMask = 4'b1111; bus.aluResult = 16'h0000;
         bus.push = 1;
         step($sformatf("stall%0d", i), 4'b0000, 1, 0, 0);
      end
      bus.flagWe = 1; bus.flagMask = 4'b1111; bus.aluResult = 16'h0000;
      step("stall_rel", 4'b0001, 1, 0, 0);

      // interrupt nest
      bus.loadEn = 1; bus.loadFlags = 4'b0101;
      step("load0101", 4'b0101, 1, 0, 0);
      bus.push = 1;
      step("push1", 4'b0101, 0, 0, 0);
      bus.loadEn = 1; bus.loadFlags = 4'b1010;
      step("load1010", 4'b1010, 0, 0, 0);
      bus.push = 1;
      step("push2", 4'b1010, 0, 0, 0);
      bus.flagWe = 1; bus.flagMask = 4'b0001; bus.aluResult = 16'h0000;
      step("wb_z", 4'b1011, 0, 0, 0);
      bus.pop = 1;
      step("pop1", 4'b1010, 0, 0, 0);
      bus.pop = 1; bus.loadEn = 1; bus.loadFlags = 4'b1111;
      step("pop2_ld", 4'b0101, 1, 0, 0);

      // push saves pre-update flags while a load updates the live ones
      bus.push = 1; bus.loadEn = 1; bus.loadFlags = 4'b0110;
      step("push_ld", 4'b0110, 0, 0, 0);
      bus.pop = 1; bus.push = 1;
      step("pop_push", 4'b0101, 1, 0, 0);

      // fill, overflow, drain, underflow
      for (int i = 1; i <= 5; i++) begin
         bus.push = 1;
         step($sformatf("fill%0d", i), 4'b0101, 0, (i >= 4), (i == 5));
      end
      for (int i = 3; i >= 0; i--) begin
         bus.pop = 1;
         step($sformatf("drain%0d", i), 4'b0101, (i == 0), 0, 1);
      end
      bus.pop = 1; bus.loadEn = 1; bus.loadFlags = 4'b0011;
      step("pop_empty_ld", 4'b0011, 1, 0, 1);

      // asynchronous reset between edges
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      pushExp("async_rst", 4'b0000, 1, 0, 0);
      #1;
      checkOut();
      #2;
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule

// File: doc/flag_status_unit.md
Name: flag_status_unit

Overview:
- Registered status-flag producer for the RISC datapath; branch resolution consumes its zFlag, carryFlag, signFlag and overflowFlag outputs.
- On each qualified ALU writeback it derives Z/C/S/V from the ALU result and operand sign bits.
- Per-flag update masks let logic and shift ops leave C/V untouched.
- Holds a small LIFO flag stack so interrupt entry and return can save and restore flags, and supports a direct software load of all four flags.

Parameters:
- WIDTH, 16, ALU datapath width in bits.
- STACK_DEPTH, 4, number of 4-bit flag entries in the save stack (power of two, >=2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall; when 1 no state changes.
- flagWe  in  1  ALU writeback qualifier; enables flag update this cycle.
- flagMask  in  4  per-flag update enable {V,S,C,Z}; bit=1 updates that flag.
- isSub  in  1  1 = subtract/compare; selects overflow rule.
- aluResult  in  WIDTH  ALU result.
- opAMsb  in  1  MSB of operand A.
- opBMsb  in  1  MSB of operand B (unmodified, before inversion for sub).
- carryOut  in  1  adder carry-out.
- loadEn  in  1  direct flag load (move-to-status).
- loadFlags  in  4  {V,S,C,Z} value for loadEn.
- push  in  1  interrupt entry: save current flags.
- pop  in  1  return from interrupt: restore flags.
- zFlag  out  1  registered zero flag.
- carryFlag  out  1  registered carry flag.
- signFlag  out  1  registered sign flag.
- overflowFlag  out  1  registered overflow flag.
- stackEmpty  out  1  stack holds 0 entries.
- stackFull  out  1  stack holds STACK_DEPTH entries.
- stackErr  out  1  sticky: push-when-full or pop-when-empty occurred.

Behaviour:
- Reset (rst_n=0, async): all four flags 0, stack pointer 0, stackEmpty=1, stackFull=0, stackErr=0. Stack entry contents are don't-care.
- Computed values, combinational from the inputs:
  - Z = (aluResult == 0).
  - S = aluResult[WIDTH-1].
  - C = carryOut.
  - add (isSub=0): V = (opAMsb==opBMsb) & (S!=opAMsb).
  - sub (isSub=1): V = (opAMsb!=opBMsb) & (S!=opAMsb).
- Latency: flags reflect an update on the edge after the qualifying inputs. Outputs come straight from the registers; no combinational input-to-output path.
- stall=1: flags, stack pointer, stack contents and stackErr hold. All other inputs are ignored that cycle.
- Priority when stall=0, highest first:
  1. pop
  2. loadEn
  3. flagWe
  - Exactly one of these writes the flags per cycle.
- pop, stack non-empty: flags <= top entry, pointer decrements. Simultaneous loadEn/flagWe are discarded.
- pop, stack empty: flags unchanged, pointer stays 0, stackErr <= 1. The lower-priority loadEn/flagWe then applies normally.
- loadEn: all four flags <= loadFlags, regardless of flagMask.
- flagWe: each flag with its flagMask bit = 1 takes its computed value; masked flags hold. flagMask=0000 with flagWe=1 is a no-op.
- push, not full: entry[pointer] <= current (pre-update) flag register, pointer increments. A simultaneous flagWe/loadEn still updates the live flags that same cycle.
- push, full: nothing pushed, stackErr <= 1, other actions proceed.
- push and pop in the same cycle: push is ignored. Pop behaves as above; stackErr is unaffected by the ignored push.
- stackEmpty = (pointer==0); stackFull = (pointer==STACK_DEPTH). Both are registered-state derived.
- stackErr is sticky and clears only on reset.
- Reset asserted mid-operation clears all state immediately, independent of clk.

Test Plan:
- Reset then idle: rst_n low with flagWe=1 -> all flags 0, stackEmpty=1, stackErr=0. After release, no change until a qualifying input.
- Add overflow: flagWe=1, mask=1111, isSub=0, opAMsb=0, opBMsb=0, aluResult=16'h8000, carryOut=0 -> next cycle Z=0, C=0, S=1, V=1.
- Compare-equal with mask: isSub=1, aluResult=16'h0000, carryOut=1, opAMsb=opBMsb=1, mask=0011 after flags {V,S,C,Z}=1100 -> Z=1, C=1, S=1, V=1.
- Stall: flagWe=1, aluResult=0, stall=1 for 3 cycles -> flags unchanged. Release -> Z=1 one cycle later.
- Interrupt nest: load 0101, push; load 1010, push; flagWe result 0 with mask=0001, then pop -> flags return to 1010; second pop -> 0101 and stackEmpty=1.
- Overflow/underflow: 5 pushes with STACK_DEPTH=4 -> stackFull=1 after the 4th push, stackErr=1 after the 5th. Pop on an empty stack with loadEn=1 and loadFlags=0011 -> flags=0011, stackErr stays 1.
